// File: rtl/config_sequencer_if.sv
// Host-side and broadcast-side signal bundle of the configuration sequencer.
// The host drives the table/start controls, and the sequencer drives status and the config bus.
interface config_sequencer_if #(
    parameter int NUM_BLOCKS = 4,
    parameter int MAX_CHAINS = 4
) ();
    localparam int ADDR_W = $clog2(NUM_BLOCKS * 2 * MAX_CHAINS);

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [7:0]            wr_data;
    logic                  wr_ready;
    logic                  start;
    logic [NUM_BLOCKS-1:0] load_mask;
    logic                  tracing_en;
    logic                  busy;
    logic                  done;
    logic                  tracing;
    logic [7:0]            configId;
    logic [7:0]            configData;

    modport master (
        output wr_en, wr_addr, wr_data, start, load_mask, tracing_en,
        input  wr_ready, busy, done, tracing, configId, configData
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, load_mask, tracing_en,
        output wr_ready, busy, done, tracing, configId, configData
    );
endinterface

// File: rtl/config_sequencer.sv
// Reprograms the instrumentation blocks. On start it drops tracing and drains in-flight data.
// It then streams each selected block's table bytes under that block's config ID, and finally restores tracing.
module config_sequencer #(
    parameter int NUM_BLOCKS      = 4,
    parameter int MAX_CHAINS      = 4,
    parameter int FIRST_CONFIG_ID = 1,
    parameter int IDLE_CONFIG_ID  = 255,
    parameter int DRAIN_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    config_sequencer_if.slave bus
);
    localparam int BYTES_PER_BLOCK = 2 * MAX_CHAINS;
    localparam int DEPTH           = NUM_BLOCKS * BYTES_PER_BLOCK;
    localparam int ADDR_W          = $clog2(DEPTH);
    localparam int BLK_W           = $clog2(NUM_BLOCKS) + 1;
    localparam int BYTE_W          = $clog2(BYTES_PER_BLOCK) + 1;
    localparam int DRAIN_W         = $clog2(DRAIN_CYCLES + 1);

    localparam logic [7:0]         IDLE_ID    = 8'(IDLE_CONFIG_ID);
    localparam logic [BLK_W-1:0]   NO_BLK     = BLK_W'(NUM_BLOCKS);
    localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(BYTES_PER_BLOCK - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W:0]    DEPTH_L    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                state_r;
    logic [7:0]            mem_r [DEPTH];
    logic                  tracing_r;
    logic [7:0]            config_id_r;
    logic [7:0]            config_data_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  wr_ready_r;
    logic [NUM_BLOCKS-1:0] mask_r;
    logic [BLK_W-1:0]      blk_r;
    logic [BYTE_W-1:0]     byte_r;
    logic [DRAIN_W-1:0]    drain_cnt_r;
    logic [BLK_W-1:0]      first_sel_s;
    logic [BLK_W-1:0]      next_sel_s;

    // Lowest selected block index at or above 'from'. It returns NO_BLK when none remain, so the index never wraps.
    function automatic logic [BLK_W-1:0] next_sel(input logic [NUM_BLOCKS-1:0] mask,
                                                  input logic [BLK_W-1:0]      from);
        logic [BLK_W-1:0] sel;
        sel = NO_BLK;
        for (int k = NUM_BLOCKS - 1; k >= 0; k--) begin
            if (mask[k] && (BLK_W'(k) >= from)) begin
                sel = BLK_W'(k);
            end
        end
        return sel;
    endfunction

    function automatic logic [ADDR_W-1:0] tbl_addr(input logic [BLK_W-1:0]  blk,
                                                   input logic [BYTE_W-1:0] idx);
        return ADDR_W'(int'(blk) * BYTES_PER_BLOCK + int'(idx));
    endfunction

    function automatic logic [7:0] blk_id(input logic [BLK_W-1:0] blk);
        return 8'(FIRST_CONFIG_ID + int'(blk));
    endfunction

    assign first_sel_s = next_sel(mask_r, {BLK_W{1'b0}});
    assign next_sel_s  = next_sel(mask_r, blk_r + BLK_W'(1));

    // Firmware table: cleared on reset, written by the host only while no pass is running
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (bus.wr_en && !busy_r && ({1'b0, bus.wr_addr} < DEPTH_L)) begin
            mem_r[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Pass sequencer: every output is loaded one edge ahead of the cycle it describes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            tracing_r     <= 1'b0;
            config_id_r   <= IDLE_ID;
            config_data_r <= 8'h00;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            wr_ready_r    <= 1'b1;
            mask_r        <= {NUM_BLOCKS{1'b0}};
            blk_r         <= {BLK_W{1'b0}};
            byte_r        <= {BYTE_W{1'b0}};
            drain_cnt_r   <= {DRAIN_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    config_id_r   <= IDLE_ID;
                    config_data_r <= 8'h00;
                    if (bus.start) begin
                        mask_r      <= bus.load_mask;
                        drain_cnt_r <= {DRAIN_W{1'b0}};
                        tracing_r   <= 1'b0;
                        busy_r      <= 1'b1;
                        wr_ready_r  <= 1'b0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        tracing_r   <= bus.tracing_en;
                        busy_r      <= 1'b0;
                        wr_ready_r  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        if (first_sel_s != NO_BLK) begin
                            state_r       <= ST_LOAD;
                            blk_r         <= first_sel_s;
                            byte_r        <= {BYTE_W{1'b0}};
                            config_id_r   <= blk_id(first_sel_s);
                            config_data_r <= mem_r[tbl_addr(first_sel_s, {BYTE_W{1'b0}})];
                        end else begin
                            state_r       <= ST_FLUSH;
                        end
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (byte_r == BYTE_LAST) begin
                        // Back-to-back blocks: the ID change alone restarts the receivers' byte counters
                        if (next_sel_s != NO_BLK) begin
                            blk_r         <= next_sel_s;
                            byte_r        <= {BYTE_W{1'b0}};
                            config_id_r   <= blk_id(next_sel_s);
                            config_data_r <= mem_r[tbl_addr(next_sel_s, {BYTE_W{1'b0}})];
                        end else begin
                            state_r       <= ST_FLUSH;
                            config_id_r   <= IDLE_ID;
                            config_data_r <= 8'h00;
                        end
                    end else begin
                        byte_r        <= byte_r + BYTE_W'(1);
                        config_data_r <= mem_r[tbl_addr(blk_r, byte_r + BYTE_W'(1))];
                    end
                end
                ST_FLUSH: begin
                    state_r       <= ST_IDLE;
                    config_id_r   <= IDLE_ID;
                    config_data_r <= 8'h00;
                    tracing_r     <= bus.tracing_en;
                    busy_r        <= 1'b0;
                    wr_ready_r    <= 1'b1;
                    done_r        <= 1'b1;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    tracing_r     <= 1'b0;
                    config_id_r   <= IDLE_ID;
                    config_data_r <= 8'h00;
                    busy_r        <= 1'b0;
                    wr_ready_r    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tracing    = tracing_r;
    assign bus.configId   = config_id_r;
    assign bus.configData = config_data_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.wr_ready   = wr_ready_r;
endmodule

// File: tb/tb_config_sequencer.sv
// Bench for config_sequencer: a queue-based pass model predicts every output cycle.
// Directed and random stimulus drive the design, with literal expectations for the scenarios of interest.
`timescale 1ns/1ps
module tb_config_sequencer;
    localparam int NB    = 4;
    localparam int MC    = 4;
    localparam int B     = 2 * MC;
    localparam int DEPTH = NB * B;
    localparam int DRAIN = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    config_sequencer_if #(.NUM_BLOCKS(NB), .MAX_CHAINS(MC)) bus ();

    config_sequencer #(
        .NUM_BLOCKS(NB), .MAX_CHAINS(MC), .FIRST_CONFIG_ID(1),
        .IDLE_CONFIG_ID(255), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    typedef struct {
        logic       tracing;
        logic [7:0] id;
        logic [7:0] data;
        logic       busy;
        logic       done;
        logic       rdy;
        bit         trc_from_en;
    } exp_t;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic exp_t mk(input logic t, input logic [7:0] id, input logic [7:0] d,
                                input logic bz, input logic dn, input logic rd, input bit te);
        exp_t e;
        e.tracing = t; e.id = id; e.data = d; e.busy = bz; e.done = dn; e.rdy = rd; e.trc_from_en = te;
        return e;
    endfunction

    // Reference model: a table copy plus a queue holding the remaining output cycles of the current pass
    logic [7:0] mem_m [DEPTH];
    exp_t       q [$];
    exp_t       cur;
    bit         model_ok = 1'b0;

    task automatic build_pass(input logic [NB-1:0] m);
        for (int i = 0; i < DRAIN; i++) q.push_back(mk(1'b0, 8'd255, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < NB; k++)
            if (m[k])
                for (int j = 0; j < B; j++)
                    q.push_back(mk(1'b0, 8'(k + 1), mem_m[k * B + j], 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 8'd255, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 8'd255, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1));
    endtask

    task automatic model_step();
        exp_t e;
        if (!resetn) begin
            foreach (mem_m[i]) mem_m[i] = 8'd0;
            q.delete();
            cur = mk(1'b0, 8'd255, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            model_ok = 1'b1;
        end else begin
            if (q.size() == 0) begin
                if (bus.wr_en) mem_m[bus.wr_addr] = bus.wr_data;
                if (bus.start) build_pass(bus.load_mask);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.trc_from_en) e.tracing = bus.tracing_en;
                cur = e;
            end else begin
                cur = mk(bus.tracing_en, 8'd255, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare, busy-run measurement and LOAD capture, all sampled mid-cycle
    int          run_len  = 0;
    int          last_len = 0;
    bit          cap_en   = 1'b0;
    logic [15:0] cap_q [$];

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("tracing",    bus.tracing,    cur.tracing);
            chk("configId",   bus.configId,   cur.id);
            chk("configData", bus.configData, cur.data);
            chk("busy",       bus.busy,       cur.busy);
            chk("done",       bus.done,       cur.done);
            chk("wr_ready",   bus.wr_ready,   cur.rdy);
        end
        if (bus.busy === 1'b1) run_len++;
        else begin
            if (run_len > 0) last_len = run_len;
            run_len = 0;
        end
        if (cap_en && bus.busy === 1'b1 && bus.configId !== 8'd255)
            cap_q.push_back({bus.configId, bus.configData});
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'd0;
        bus.start = 1'b0; bus.load_mask = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic run_pass(input logic [NB-1:0] m);
        bus.start = 1'b1; bus.load_mask = m;
        tick();
        bus.start = 1'b0;
        wait_idle();
        chk("done_at_end", bus.done, 1'b1);
        tick();
    endtask

    initial begin
        logic [7:0] exp2 [B];
        logic [7:0] acc;
        int n;
        exp2 = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
        idle_inputs();
        bus.tracing_en = 1'b0;

        // Reset state
        do_reset();
        chk("rst_configId", bus.configId, 8'd255);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_wr_ready", bus.wr_ready, 1'b1);

        // All four blocks, default table
        cap_q.delete(); cap_en = 1'b1;
        run_pass(4'b1111);
        cap_en = 1'b0;
        chk("t1_busy_len", last_len, 35);
        chk("t1_cap_len", cap_q.size(), 32);
        for (int i = 0; i < cap_q.size(); i++) begin
            chk("t1_id", cap_q[i][15:8], 8'(i / 8 + 1));
            chk("t1_data", cap_q[i][7:0], 8'h00);
        end

        // Single block with programmed bytes
        wr(5'd9, 8'h05);
        wr(5'd13, 8'h02);
        cap_q.delete(); cap_en = 1'b1;
        run_pass(4'b0010);
        cap_en = 1'b0;
        chk("t2_busy_len", last_len, 11);
        chk("t2_cap_len", cap_q.size(), 8);
        for (int i = 0; i < cap_q.size() && i < B; i++) begin
            chk("t2_id", cap_q[i][15:8], 8'd2);
            chk("t2_data", cap_q[i][7:0], exp2[i]);
        end

        // Empty mask: drain plus flush only, tracing comes back with done
        bus.tracing_en = 1'b1;
        repeat (2) tick();
        chk("t3_tracing_pre", bus.tracing, 1'b1);
        bus.start = 1'b1; bus.load_mask = 4'b0000;
        tick();
        bus.start = 1'b0;
        wait_idle();
        chk("t3_done", bus.done, 1'b1);
        chk("t3_tracing_at_done", bus.tracing, 1'b1);
        tick();
        chk("t3_busy_len", last_len, 3);

        // start held high and a write attempted mid-pass
        bus.start = 1'b1; bus.load_mask = 4'b0001;
        tick();
        tick();
        wr(5'd0, 8'hAA);
        wait_idle();
        bus.start = 1'b0;
        tick();
        chk("t4_single_pass", bus.busy, 1'b0);
        cap_q.delete(); cap_en = 1'b1;
        run_pass(4'b0001);
        cap_en = 1'b0;
        chk("t4_byte0", (cap_q.size() > 0) ? {24'd0, cap_q[0][7:0]} : 32'hFFFF_FFFF, 32'h0);

        // Reset on the fifth LOAD cycle
        bus.start = 1'b1; bus.load_mask = 4'b1111;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.configId === 8'd255 && n < 20) begin tick(); n++; end
        chk("t5_reached_load", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) tick();
        resetn = 1'b0;
        tick();
        chk("t5_id", bus.configId, 8'd255);
        chk("t5_tracing", bus.tracing, 1'b0);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_done", bus.done, 1'b0);
        resetn = 1'b1;
        tick();
        cap_q.delete(); cap_en = 1'b1;
        run_pass(4'b1111);
        cap_en = 1'b0;
        acc = 8'h00;
        foreach (cap_q[i]) acc = acc | cap_q[i][7:0];
        chk("t5_cleared", acc, 8'h00);
        chk("t5_cap_len", cap_q.size(), 32);

        // tracing_en follows in idle, ignored while busy
        bus.tracing_en = 1'b0;
        tick();
        chk("t6_follow_low", bus.tracing, 1'b0);
        bus.tracing_en = 1'b1;
        tick();
        chk("t6_follow_high", bus.tracing, 1'b1);
        bus.start = 1'b1; bus.load_mask = 4'b0100;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.tracing_en = ~bus.tracing_en;
            tick();
            chk("t6_busy_tracing", bus.tracing, 1'b0);
        end
        bus.tracing_en = 1'b1;
        wait_idle();
        chk("t6_resume", bus.tracing, 1'b1);

        // Random traffic, including occasional resets
        for (int c = 0; c < 1500; c++) begin
            bus.wr_en      = ($urandom_range(0, 3) == 0);
            bus.wr_addr    = 5'($urandom_range(0, DEPTH - 1));
            bus.wr_data    = 8'($urandom);
            bus.start      = ($urandom_range(0, 24) == 0);
            bus.load_mask  = 4'($urandom);
            bus.tracing_en = 1'($urandom);
            resetn         = ($urandom_range(0, 199) != 0);
            tick();
        end
        idle_inputs();
        resetn = 1'b1;
        tick();
        wait_idle();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
